// File: rtl/lsu_mem_initiator.sv
// Load/store initiator between the execute/memory stage and the four-bank byte-lane memory unit.
// Optional build macro: LSU_MISALIGN_TRAP_EN (reject misaligned half/word requests with resp_err).
`timescale 1ns/1ps

module lsu_mem_initiator #(
  parameter int unsigned MEM_ADDR_W   = 10,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_funct3,
  input  logic [31:0]           req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [31:0]           resp_rdata,
  output logic                  resp_err,
  output logic [MEM_ADDR_W-1:0] mem_address,
  output logic [31:0]           mem_in,
  output logic                  mem_wren,
  output logic [1:0]            mem_width,
  input  logic [31:0]           mem_out
);

  localparam int unsigned CNT_W = 3;
  localparam logic [1:0] WIDTH_BYTE = 2'b00;
  localparam logic [1:0] WIDTH_HALF = 2'b01;
  localparam logic [1:0] WIDTH_WORD = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_WAIT   = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  state_t                r_state, w_state_nxt;
  logic                  r_we, w_we_nxt;
  logic [2:0]            r_funct3, w_funct3_nxt;
  logic [CNT_W-1:0]      r_cnt, w_cnt_nxt;
  logic                  r_req_ready, w_req_ready_nxt;
  logic                  r_resp_valid, w_resp_valid_nxt;
  logic [31:0]           r_resp_rdata, w_resp_rdata_nxt;
  logic                  r_resp_err, w_resp_err_nxt;
  logic [MEM_ADDR_W-1:0] r_mem_address, w_mem_address_nxt;
  logic [31:0]           r_mem_in, w_mem_in_nxt;
  logic                  r_mem_wren, w_mem_wren_nxt;
  logic [1:0]            r_mem_width, w_mem_width_nxt;

  logic                  w_f3_legal;
  logic                  w_misalign;
  logic                  w_req_illegal;
  logic [1:0]            w_req_width;
  logic [31:0]           w_load_ext;
  logic                  w_unused;

  assign w_unused = ^req_addr[31:MEM_ADDR_W];

  // Request decode: memory-unit width code and funct3 legality
  always_comb begin
    w_req_width = WIDTH_WORD;
    case (req_funct3[1:0])
      2'b00:   w_req_width = WIDTH_BYTE;
      2'b01:   w_req_width = WIDTH_HALF;
      default: w_req_width = WIDTH_WORD;
    endcase
    if (req_we) begin
      w_f3_legal = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) || (req_funct3 == 3'b010);
    end else begin
      w_f3_legal = (req_funct3 != 3'b011) && (req_funct3 != 3'b110) && (req_funct3 != 3'b111);
    end
  end

`ifdef LSU_MISALIGN_TRAP_EN
  assign w_misalign = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                      ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
`else
  assign w_misalign = 1'b0;
`endif

  assign w_req_illegal = !w_f3_legal || w_misalign;

  // Load alignment: addressed byte/halfword arrives left-justified on mem_out
  always_comb begin
    w_load_ext = mem_out;
    case (r_funct3)
      3'b000:  w_load_ext = {{24{mem_out[31]}}, mem_out[31:24]};
      3'b100:  w_load_ext = {24'd0, mem_out[31:24]};
      3'b001:  w_load_ext = {{16{mem_out[31]}}, mem_out[31:16]};
      3'b101:  w_load_ext = {16'd0, mem_out[31:16]};
      default: w_load_ext = mem_out;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next state and registered outputs
  always_comb begin
    w_state_nxt       = r_state;
    w_we_nxt          = r_we;
    w_funct3_nxt      = r_funct3;
    w_cnt_nxt         = r_cnt;
    w_req_ready_nxt   = r_req_ready;
    w_resp_valid_nxt  = r_resp_valid;
    w_resp_rdata_nxt  = r_resp_rdata;
    w_resp_err_nxt    = r_resp_err;
    w_mem_address_nxt = r_mem_address;
    w_mem_in_nxt      = r_mem_in;
    w_mem_width_nxt   = r_mem_width;
    w_mem_wren_nxt    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (req_valid && r_req_ready) begin
          w_we_nxt        = req_we;
          w_funct3_nxt    = req_funct3;
          w_req_ready_nxt = 1'b0;
          if (w_req_illegal) begin
            w_state_nxt      = S_RESP;
            w_resp_valid_nxt = 1'b1;
            w_resp_err_nxt   = 1'b1;
            w_resp_rdata_nxt = 32'd0;
          end else begin
            w_state_nxt       = S_ACCESS;
            w_mem_address_nxt = req_addr[MEM_ADDR_W-1:0];
            w_mem_in_nxt      = req_wdata;
            w_mem_width_nxt   = w_req_width;
            w_mem_wren_nxt    = req_we;
          end
        end
      end
      S_ACCESS: begin
        if (r_we) begin
          w_state_nxt      = S_RESP;
          w_resp_valid_nxt = 1'b1;
          w_resp_err_nxt   = 1'b0;
          w_resp_rdata_nxt = 32'd0;
        end else begin
          w_state_nxt = S_WAIT;
          w_cnt_nxt   = CNT_W'(READ_LATENCY);
        end
      end
      S_WAIT: begin
        if (r_cnt <= CNT_W'(1)) begin
          w_state_nxt      = S_RESP;
          w_resp_valid_nxt = 1'b1;
          w_resp_err_nxt   = 1'b0;
          w_resp_rdata_nxt = w_load_ext;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      S_RESP: begin
        if (resp_ready) begin
          w_state_nxt      = S_IDLE;
          w_resp_valid_nxt = 1'b0;
          w_req_ready_nxt  = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_we          <= 1'b0;
      r_funct3      <= 3'd0;
      r_cnt         <= '0;
      r_req_ready   <= 1'b1;
      r_resp_valid  <= 1'b0;
      r_resp_rdata  <= 32'd0;
      r_resp_err    <= 1'b0;
      r_mem_address <= '0;
      r_mem_in      <= 32'd0;
      r_mem_wren    <= 1'b0;
      r_mem_width   <= WIDTH_WORD;
    end else begin
      r_we          <= w_we_nxt;
      r_funct3      <= w_funct3_nxt;
      r_cnt         <= w_cnt_nxt;
      r_req_ready   <= w_req_ready_nxt;
      r_resp_valid  <= w_resp_valid_nxt;
      r_resp_rdata  <= w_resp_rdata_nxt;
      r_resp_err    <= w_resp_err_nxt;
      r_mem_address <= w_mem_address_nxt;
      r_mem_in      <= w_mem_in_nxt;
      r_mem_wren    <= w_mem_wren_nxt;
      r_mem_width   <= w_mem_width_nxt;
    end
  end

  // Reset gates ready and write strobe immediately so a reset during ACCESS never writes
  assign req_ready   = r_req_ready & ~reset;
  assign mem_wren    = r_mem_wren & ~reset;
  assign resp_valid  = r_resp_valid;
  assign resp_rdata  = r_resp_rdata;
  assign resp_err    = r_resp_err;
  assign mem_address = r_mem_address;
  assign mem_in      = r_mem_in;
  assign mem_width   = r_mem_width;

endmodule

// File: tb/tb_lsu_mem_initiator.sv
// Bench for lsu_mem_initiator: byte-array memory model plus an independent byte-array reference.
`timescale 1ns/1ps

module tb_lsu_mem_initiator;

  localparam int unsigned AW = 10;
  localparam int unsigned RL = 1;
  localparam int unsigned DEPTH = 1 << AW;
`ifdef LSU_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          req_valid, req_ready, req_we;
  logic [2:0]    req_funct3;
  logic [31:0]   req_addr, req_wdata;
  logic          resp_valid, resp_ready, resp_err;
  logic [31:0]   resp_rdata;
  logic [AW-1:0] mem_address;
  logic [31:0]   mem_in, mem_out;
  logic          mem_wren;
  logic [1:0]    mem_width;

  always #5 clk = ~clk;

  lsu_mem_initiator #(.MEM_ADDR_W(AW), .READ_LATENCY(RL)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_address(mem_address), .mem_in(mem_in), .mem_wren(mem_wren),
    .mem_width(mem_width), .mem_out(mem_out)
  );

  // Memory unit model: byte at address on [31:24], following bytes below it, wrapping
  logic [7:0]    env_mem [DEPTH];
  logic [31:0]   rd_pipe [RL];
  int            wren_cnt;
  logic [AW-1:0] wr_addr;
  logic [1:0]    wr_width;
  logic [31:0]   wr_in;

  assign mem_out = rd_pipe[RL-1];

  always @(posedge clk) begin
    if (mem_wren) begin
      wren_cnt = wren_cnt + 1;
      wr_addr  = mem_address;
      wr_width = mem_width;
      wr_in    = mem_in;
      case (mem_width)
        2'b00: env_mem[mem_address] = mem_in[7:0];
        2'b01: begin
          env_mem[mem_address]          = mem_in[15:8];
          env_mem[AW'(mem_address + 1)] = mem_in[7:0];
        end
        default: begin
          env_mem[mem_address]          = mem_in[31:24];
          env_mem[AW'(mem_address + 1)] = mem_in[23:16];
          env_mem[AW'(mem_address + 2)] = mem_in[15:8];
          env_mem[AW'(mem_address + 3)] = mem_in[7:0];
        end
      endcase
    end
    rd_pipe[0] <= {env_mem[mem_address], env_mem[AW'(mem_address + 1)],
                   env_mem[AW'(mem_address + 2)], env_mem[AW'(mem_address + 3)]};
    for (int i = 1; i < RL; i++) rd_pipe[i] <= rd_pipe[i-1];
  end

  // Reference model state
  logic [7:0]    ref_mem [DEPTH];
  logic [AW-1:0] exp_addr;
  logic [1:0]    exp_width;
  int            n_vec = 0;
  int            n_err = 0;

  function automatic bit ref_legal(input bit we, input bit [2:0] f3, input bit [31:0] a);
    bit ok;
    int unsigned size;
    if (we) ok = (f3 <= 3'd2);
    else    ok = !(f3 inside {3'b011, 3'b110, 3'b111});
    size = 1 << f3[1:0];
    if (TRAP && ((a % size) != 0)) ok = 1'b0;
    return ok;
  endfunction

  function automatic logic [31:0] ref_load(input bit [2:0] f3, input logic [AW-1:0] a);
    logic [31:0] w;
    w = 32'd0;
    for (int k = 0; k < 4; k++) w = (w << 8) | 32'(ref_mem[(int'(a) + k) % DEPTH]);
    case (f3)
      3'b000:  return 32'($signed(w[31:24]));
      3'b100:  return 32'(w[31:24]);
      3'b001:  return 32'($signed(w[31:16]));
      3'b101:  return 32'(w[31:16]);
      default: return w;
    endcase
  endfunction

  task automatic ref_store(input bit [2:0] f3, input logic [AW-1:0] a, input logic [31:0] wd);
    int nb;
    nb = 1 << f3[1:0];
    for (int k = 0; k < nb; k++)
      ref_mem[(int'(a) + k) % DEPTH] = 8'(wd >> (8 * (nb - 1 - k)));
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_values();
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_err", 32'(resp_err), 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_mem_wren", 32'(mem_wren), 32'd0);
    chk("rst_mem_address", 32'(mem_address), 32'd0);
    chk("rst_mem_in", mem_in, 32'd0);
    chk("rst_mem_width", 32'(mem_width), 32'd3);
    chk("rst_req_ready_low", 32'(req_ready), 32'd0);
  endtask

  task automatic txn(input bit we, input bit [2:0] f3, input logic [31:0] a,
                     input logic [31:0] wd, input int stall);
    bit            legal;
    logic [AW-1:0] aa;
    logic [31:0]   er;
    int            elat, lat, g;
    legal = ref_legal(we, f3, a);
    aa    = a[AW-1:0];
    er    = (legal && !we) ? ref_load(f3, aa) : 32'd0;
    elat  = !legal ? 1 : (we ? 2 : 2 + RL);
    g = 0;
    while (!req_ready && g < 20) begin @(posedge clk); #1; g++; end
    chk("req_ready_idle", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
    resp_ready = 1'b0; wren_cnt = 0;
    @(posedge clk); #1;
    req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom; req_funct3 = 3'($urandom);
    lat = 1;
    while (!resp_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    if (legal) begin
      exp_addr  = aa;
      exp_width = (f3[1:0] == 2'b10) ? 2'b11 : f3[1:0];
    end
    chk("latency", 32'(lat), 32'(elat));
    chk("resp_err", 32'(resp_err), 32'(!legal));
    chk("resp_rdata", resp_rdata, er);
    chk("req_ready_busy", 32'(req_ready), 32'd0);
    chk("mem_address", 32'(mem_address), 32'(exp_addr));
    chk("mem_width", 32'(mem_width), 32'(exp_width));
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      chk("stall_valid", 32'(resp_valid), 32'd1);
      chk("stall_rdata", resp_rdata, er);
      chk("stall_ready", 32'(req_ready), 32'd0);
      chk("stall_addr", 32'(mem_address), 32'(exp_addr));
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    chk("resp_drop", 32'(resp_valid), 32'd0);
    chk("ready_back", 32'(req_ready), 32'd1);
    chk("wren_pulses", 32'(wren_cnt), (legal && we) ? 32'd1 : 32'd0);
    if (legal && we) begin
      chk("wr_addr", 32'(wr_addr), 32'(aa));
      chk("wr_width", 32'(wr_width), 32'(exp_width));
      chk("wr_in", wr_in, wd);
      ref_store(f3, aa, wd);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < int'(DEPTH); i++) begin
      env_mem[i] = 8'(i * 37 + 5);
      ref_mem[i] = 8'(i * 37 + 5);
    end
    wren_cnt = 0;
    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
    req_addr = 32'd0; req_wdata = 32'd0; resp_ready = 1'b0;
    exp_addr = '0; exp_width = 2'b11;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_values();
    reset = 1'b0;
    #1;
    chk("req_ready_after_reset", 32'(req_ready), 32'd1);

    txn(1'b1, 3'b010, 32'h010, 32'h1122_3344, 0);
    txn(1'b0, 3'b010, 32'h010, 32'd0, 0);
    chk("lw_const", resp_rdata, 32'h1122_3344);
    txn(1'b1, 3'b000, 32'h021, 32'h0000_00F0, 0);
    txn(1'b0, 3'b000, 32'h021, 32'd0, 0);
    chk("lb_const", resp_rdata, 32'hFFFF_FFF0);
    txn(1'b0, 3'b100, 32'h021, 32'd0, 0);
    chk("lbu_const", resp_rdata, 32'h0000_00F0);
    txn(1'b1, 3'b001, 32'h032, 32'h0000_8001, 0);
    txn(1'b0, 3'b001, 32'h032, 32'd0, 0);
    chk("lh_const", resp_rdata, 32'hFFFF_8001);
    txn(1'b0, 3'b101, 32'h032, 32'd0, 0);
    chk("lhu_const", resp_rdata, 32'h0000_8001);
    txn(1'b0, 3'b011, 32'h040, 32'd0, 0);
    txn(1'b1, 3'b100, 32'h044, 32'h5555_AAAA, 1);
    txn(1'b0, 3'b010, 32'h010, 32'd0, 5);
    txn(1'b0, 3'b010, 32'hFFFF_F010, 32'd0, 0);

    // Reset landing on the ACCESS cycle of a store
    txn(1'b0, 3'b010, 32'h050, 32'd0, 0);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010;
    req_addr = 32'h050; req_wdata = 32'hDEAD_BEEF; wren_cnt = 0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    reset = 1'b1;
    #1;
    chk("rst_wren_gate", 32'(mem_wren), 32'd0);
    @(posedge clk); #1;
    chk_reset_values();
    reset = 1'b0;
    #1;
    chk("rst_no_write", 32'(wren_cnt), 32'd0);
    chk("rst_ready_back", 32'(req_ready), 32'd1);
    exp_addr = '0; exp_width = 2'b11;
    txn(1'b0, 3'b010, 32'h050, 32'd0, 0);

    txn(1'b0, 3'b010, 32'h011, 32'd0, 0);
    txn(1'b1, 3'b001, 32'h063, 32'h0000_BEEF, 0);
    txn(1'b0, 3'b101, 32'h063, 32'd0, 0);

    for (int n = 0; n < 60; n++) begin
      txn(1'($urandom), 3'($urandom), {$urandom_range(0, 255) << 10} | $urandom_range(0, 63),
          $urandom, $urandom_range(0, 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/lsu_mem_initiator.md
Name: lsu_mem_initiator

Overview:
- Load/store initiator that sits between the core's execute/memory stage and the four-bank byte-lane memory unit.
- Accepts one RISC-V load or store request per transaction over a valid/ready handshake.
- Drives the memory unit's address/in/wren/width port and holds the address stable across the synchronous-RAM read latency.
- Aligns and sign- or zero-extends load data, then returns the result over a valid/ready response channel.

Parameters:
- MEM_ADDR_W, 10, width of the memory unit byte address; req_addr is truncated to this width.
- READ_LATENCY, 1, cycles from address presentation until mem_out is valid; range 1..4.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RISC-V funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW).
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-justified.
- resp_valid  out  1  response present.
- resp_ready  in  1  consumer accepts the response.
- resp_rdata  out  32  extended load data; 0 for stores and errors.
- resp_err  out  1  request rejected, no memory access performed.
- mem_address  out  MEM_ADDR_W  to memory unit address.
- mem_in  out  32  to memory unit data in.
- mem_wren  out  1  to memory unit write enable.
- mem_width  out  2  to memory unit width: 00 byte, 01 half, 11 word.
- mem_out  in  32  from memory unit; the addressed byte is at [31:24], a halfword at [31:16].

Behaviour:
- Clock and reset are fixed: one clock, clk; reset is synchronous and active-high.
- Reset values:
  - State = IDLE.
  - req_ready = 0 during reset, 1 in the first IDLE cycle after reset.
  - resp_valid = 0, resp_err = 0, resp_rdata = 0.
  - mem_wren = 0, mem_address = 0, mem_in = 0, mem_width = 11.
- Accept rule:
  - req_ready = 1 only in IDLE.
  - A handshake (req_valid & req_ready) latches we, funct3, addr[MEM_ADDR_W-1:0] and wdata into internal registers, then moves to ACCESS.
  - Upper address bits are ignored, so addresses wrap modulo 2^MEM_ADDR_W.
- Decode of funct3:
  - Width: funct3[1:0] = 00 → byte (00), 01 → half (01), 10 → word (11).
  - Illegal funct3: 011, 110, 111 for loads; anything other than 000/001/010 for stores.
  - An illegal request skips ACCESS: next state is RESP with resp_err = 1, resp_rdata = 0, and mem_wren never asserted.
- ACCESS (1 cycle):
  - mem_address, mem_width and mem_in (= wdata, unmodified) are driven from the latched registers.
  - Store: mem_wren = 1 for exactly this cycle, next state RESP.
  - Load: mem_wren = 0, the wait counter is loaded with READ_LATENCY, next state WAIT.
- WAIT:
  - Address and width are held unchanged; mem_wren = 0.
  - The counter decrements each cycle. On the cycle the counter reaches 1, mem_out is captured and extended into resp_rdata, then next state is RESP.
  - LB: sign-extend mem_out[31:24]. LBU: zero-extend it.
  - LH: sign-extend mem_out[31:16]. LHU: zero-extend it.
  - LW: mem_out unchanged.
- RESP:
  - resp_valid = 1; resp_rdata and resp_err are held stable until resp_ready = 1.
  - On the handshake, next state is IDLE and resp_valid drops the following cycle.
  - Any resp_ready stall length is legal.
- Latency from accept edge to resp_valid:
  - Store: 2 cycles.
  - Load: 2 + READ_LATENCY cycles.
  - Illegal request: 1 cycle.
  - No pipelining: at most one transaction in flight.
- Reset mid-operation: a synchronous reset in any state returns to IDLE with the reset values above. mem_wren is gated by reset, so a store whose ACCESS cycle coincides with reset performs no write.
- mem_address and mem_width hold their last value in IDLE and RESP; mem_wren = 0 in every state except store ACCESS.
- Misaligned addresses are passed through to the memory unit, which handles them by lane rotation, unless the optional feature is compiled in.

Optional Feature:
- Macro: LSU_MISALIGN_TRAP_EN.
- Defined:
  - Halfword requests with addr[0] ≠ 0 and word requests with addr[1:0] ≠ 0 are treated as illegal.
  - Response: resp_err = 1, no memory access, 1-cycle latency.
- Undefined: misaligned accesses are performed normally with no error.

Test Plan:
- SW 0x11223344 @0x010, then LW @0x010 → store resp after 2 cycles with err = 0; load resp_rdata = 0x11223344 after 3 cycles (READ_LATENCY = 1).
- SB wdata 0x000000F0 @0x021; LB @0x021 → 0xFFFFFFF0; LBU @0x021 → 0x000000F0; mem_wren is high for exactly 1 cycle with mem_width = 00.
- SH 0x00008001 @0x032; LH @0x032 → 0xFFFF8001; LHU @0x032 → 0x00008001.
- Load funct3 = 011 @0x040 → resp_err = 1 and resp_rdata = 0 one cycle after accept; mem_wren stays 0.
- LW @0x010 with resp_ready held low 5 cycles → resp_valid, resp_rdata = 0x11223344 and mem_address stay stable; req_ready = 0 throughout; accept occurs the cycle after resp_ready rises.
- SW 0xDEADBEEF @0x050 with reset asserted in the ACCESS cycle → mem_wren = 0 and all outputs at reset values; a later LW @0x050 returns the prior contents. With LSU_MISALIGN_TRAP_EN, LW @0x011 → resp_err = 1; without it, the access completes with err = 0.
